// File: rtl/sym_vn_lut_loader_pkg.sv
// Shared definitions for the symmetric VN IB-LUT loader: FSM encoding and
// page-width derivation also used by the read-side address bus.
package sym_vn_lut_loader_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GET_EVEN = 2'd1,
        GET_ODD  = 2'd2,
        WRITE    = 2'd3
    } ld_state_e;

    localparam int DEF_QUAN_SIZE      = 3;
    localparam int DEF_LUT_PORT_SIZE  = 3;
    localparam int DEF_ENTRY_ADDR     = 5;
    localparam int DEF_MULTI_FRAME    = 2;

    // One address bit per table half is taken off the top of the LUT address.
    function automatic int page_w(input int entry_addr, input int frames);
        return entry_addr - $clog2(frames);
    endfunction

endpackage

// File: rtl/sym_vn_lut_loader_if.sv
// Entry stream and LUT write-port bundle between the loader and its neighbours.
interface sym_vn_lut_loader_if #(
    parameter int LUT_PORT_SIZE = 3,
    parameter int PAGE_W        = 4
);
    logic                     load_start;
    logic                     load_offset;
    logic [LUT_PORT_SIZE-1:0] entry_in;
    logic                     entry_valid;
    logic                     entry_ready;
    logic [LUT_PORT_SIZE-1:0] lut_in_bank0;
    logic [LUT_PORT_SIZE-1:0] lut_in_bank1;
    logic [PAGE_W-1:0]        page_write_addr;
    logic                     write_addr_offset;
    logic                     we;
    logic                     busy;
    logic                     load_done;

    modport master (
        output load_start, load_offset, entry_in, entry_valid,
        input  entry_ready, lut_in_bank0, lut_in_bank1, page_write_addr,
               write_addr_offset, we, busy, load_done
    );

    modport slave (
        input  load_start, load_offset, entry_in, entry_valid,
        output entry_ready, lut_in_bank0, lut_in_bank1, page_write_addr,
               write_addr_offset, we, busy, load_done
    );
endinterface

// File: rtl/sym_vn_lut_loader.sv
// Pairs streamed LUT entries into bank0/bank1 page words and drives the
// write port of one table half while the decoder reads the other half.
module sym_vn_lut_loader
    import sym_vn_lut_loader_pkg::*;
#(
    parameter int QUAN_SIZE       = DEF_QUAN_SIZE,
    parameter int LUT_PORT_SIZE   = DEF_LUT_PORT_SIZE,
    parameter int ENTRY_ADDR      = DEF_ENTRY_ADDR,
    parameter int MULTI_FRAME_NUM = DEF_MULTI_FRAME
) (
    input  logic                write_clk,
    input  logic                rst,
    sym_vn_lut_loader_if.slave  lut_if
);
    localparam int PAGE_W = page_w(ENTRY_ADDR, MULTI_FRAME_NUM);
    localparam logic [PAGE_W-1:0] LAST_PAGE = {PAGE_W{1'b1}};

    // Quantisation width only travels through for parameter consistency.
    if (QUAN_SIZE <= 0) begin : g_bad_quan
        $error("QUAN_SIZE must be positive");
    end

    ld_state_e                r_state, w_next;
    logic [PAGE_W-1:0]        r_page;
    logic [PAGE_W-1:0]        r_page_out;
    logic [LUT_PORT_SIZE-1:0] r_hold0;
    logic [LUT_PORT_SIZE-1:0] r_bank0, r_bank1;
    logic                     r_offset;
    logic                     w_ready, w_we, w_done;

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE:     if (lut_if.load_start) w_next = GET_EVEN;
            GET_EVEN: begin
                w_ready = 1'b1;
                if (lut_if.entry_valid) w_next = GET_ODD;
            end
            GET_ODD:  begin
                w_ready = 1'b1;
                if (lut_if.entry_valid) w_next = WRITE;
            end
            WRITE:    begin
                w_we = 1'b1;
                if (r_page == LAST_PAGE) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_next = GET_EVEN;
                end
            end
            default:  w_next = IDLE;
        endcase
    end

    // Output word is only updated on the odd handshake, so it never moves while we=0.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_page     <= '0;
            r_page_out <= '0;
            r_hold0    <= '0;
            r_bank0    <= '0;
            r_bank1    <= '0;
            r_offset   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && lut_if.load_start) begin
                r_offset <= lut_if.load_offset;
                r_page   <= '0;
            end
            if (r_state == GET_EVEN && lut_if.entry_valid)
                r_hold0 <= lut_if.entry_in;
            if (r_state == GET_ODD && lut_if.entry_valid) begin
                r_bank0    <= r_hold0;
                r_bank1    <= lut_if.entry_in;
                r_page_out <= r_page;
            end
            if (r_state == WRITE && r_page != LAST_PAGE)
                r_page <= r_page + 1'b1;
        end
    end

    assign lut_if.entry_ready       = w_ready;
    assign lut_if.we                = w_we;
    assign lut_if.load_done         = w_done;
    assign lut_if.busy              = (r_state != IDLE);
    assign lut_if.lut_in_bank0      = r_bank0;
    assign lut_if.lut_in_bank1      = r_bank1;
    assign lut_if.page_write_addr   = r_page_out;
    assign lut_if.write_addr_offset = r_offset;

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Self-checking bench: table of loading passes, scoreboard of expected page words.
module tb_sym_vn_lut_loader;
    localparam int LPS    = 3;
    localparam int PW     = 4;
    localparam int NENT   = 32;

    logic write_clk = 1'b0;
    logic rst       = 1'b1;
    always #5 write_clk = ~write_clk;

    sym_vn_lut_loader_if #(.LUT_PORT_SIZE(LPS), .PAGE_W(PW)) lif ();

    sym_vn_lut_loader #(
        .QUAN_SIZE(3), .LUT_PORT_SIZE(LPS), .ENTRY_ADDR(5), .MULTI_FRAME_NUM(2)
    ) dut (
        .write_clk (write_clk),
        .rst       (rst),
        .lut_if    (lif.slave)
    );

    typedef struct packed {
        logic [LPS-1:0] b0;
        logic [LPS-1:0] b1;
        logic [PW-1:0]  page;
        logic           off;
    } wr_t;

    typedef struct {
        logic off;
        bit   rnd;
        int   ls_at;
        bit   ls_done;
        int   n_ent;
        bit   do_rst;
        int   exp_writes;
    } vec_t;

    wr_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  wcount = 0;
    bit  done_flag = 0;
    int  cyc_done = 0;
    int  t_first = 0;

    logic [LPS-1:0] p_b0, p_b1;
    logic [PW-1:0]  p_pg;
    logic           p_off, p_busy;

    always @(posedge write_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every we pops one expected page word; between writes the port must hold still.
    always @(negedge write_clk) begin
        if (!rst) begin
            if (lif.we) begin
                if (sb.size() == 0) begin
                    chk("we_without_odd_entry", 1, 0);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("bank0", 32'(lif.lut_in_bank0), 32'(e.b0));
                    chk("bank1", 32'(lif.lut_in_bank1), 32'(e.b1));
                    chk("page", 32'(lif.page_write_addr), 32'(e.page));
                    chk("offset", 32'(lif.write_addr_offset), 32'(e.off));
                    chk("done_on_last", 32'(lif.load_done), 32'(e.page == 4'd15));
                end
                wcount++;
                if (lif.load_done) begin
                    done_flag = 1;
                    cyc_done  = cyc;
                end
            end else begin
                if (lif.load_done) chk("done_without_we", 1, 0);
                if (p_busy && lif.busy) begin
                    chk("hold_b0", 32'(lif.lut_in_bank0), 32'(p_b0));
                    chk("hold_b1", 32'(lif.lut_in_bank1), 32'(p_b1));
                    chk("hold_page", 32'(lif.page_write_addr), 32'(p_pg));
                    chk("hold_off", 32'(lif.write_addr_offset), 32'(p_off));
                end
            end
        end
        p_b0 = lif.lut_in_bank0; p_b1 = lif.lut_in_bank1;
        p_pg = lif.page_write_addr; p_off = lif.write_addr_offset;
        p_busy = lif.busy;
    end

    task automatic step();
        @(negedge write_clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int  k, g;
        bit  hs, val;
        wcount = 0; done_flag = 0;
        lif.load_start = 1'b1; lif.load_offset = v.off;
        step();
        lif.load_start = 1'b0; lif.load_offset = ~v.off;
        chk("start_busy", 32'(lif.busy), 1);
        chk("start_ready", 32'(lif.entry_ready), 1);
        k = 0; g = 0;
        while (k < v.n_ent && g < 3000) begin
            val = v.rnd ? bit'($urandom_range(0, 1)) : 1'b1;
            lif.entry_valid = val;
            lif.entry_in    = k[LPS-1:0];
            lif.load_start  = (k == v.ls_at);
            hs = val && lif.entry_ready;
            if (hs && k == 0) t_first = cyc;
            if (hs && k[0]) sb.push_back('{b0: LPS'((k-1) % 8), b1: LPS'(k % 8),
                                           page: PW'(k >> 1), off: v.off});
            step();
            g++;
            if (hs) k++;
        end
        lif.entry_valid = 1'b0;
        lif.load_start  = 1'b0;
        chk("entries_sent", 32'(k), 32'(v.n_ent));
        if (v.do_rst) begin
            g = 0;
            while (wcount < v.exp_writes && g < 100) begin step(); g++; end
            step();
            rst = 1'b1;
            #1;
            chk("rst_we", 32'(lif.we), 0);
            chk("rst_busy", 32'(lif.busy), 0);
            chk("rst_page", 32'(lif.page_write_addr), 0);
            chk("rst_ready", 32'(lif.entry_ready), 0);
            step();
            rst = 1'b0;
            chk("rst_writes", 32'(wcount), 32'(v.exp_writes));
            sb.delete();
        end else begin
            if (v.ls_done) begin
                lif.load_start = 1'b1; lif.load_offset = ~v.off;
            end
            g = 0;
            while (!done_flag && g < 100) begin step(); g++; end
            lif.load_start = 1'b0;
            chk("done_seen", 32'(done_flag), 1);
            chk("writes", 32'(wcount), 32'(v.exp_writes));
            chk("sb_empty", 32'(sb.size()), 0);
            if (!v.rnd) chk("pass_latency", 32'(cyc_done - t_first), 47);
            step();
            chk("busy_fall", 32'(lif.busy), 0);
            step();
            chk("stay_idle", 32'(lif.busy), 0);
            chk("offset_kept", 32'(lif.write_addr_offset), 32'(v.off));
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{off:1'b1, rnd:0, ls_at:-1, ls_done:0, n_ent:NENT, do_rst:0, exp_writes:16};
        vecs[1] = '{off:1'b1, rnd:1, ls_at:-1, ls_done:0, n_ent:NENT, do_rst:0, exp_writes:16};
        vecs[2] = '{off:1'b0, rnd:0, ls_at:10, ls_done:1, n_ent:NENT, do_rst:0, exp_writes:16};
        vecs[3] = '{off:1'b1, rnd:0, ls_at:-1, ls_done:0, n_ent:12,   do_rst:1, exp_writes:6};
        vecs[4] = '{off:1'b0, rnd:0, ls_at:-1, ls_done:0, n_ent:NENT, do_rst:0, exp_writes:16};
        vecs[5] = '{off:1'b1, rnd:1, ls_at:-1, ls_done:0, n_ent:NENT, do_rst:0, exp_writes:16};

        lif.load_start = 1'b0; lif.load_offset = 1'b0;
        lif.entry_in = '0; lif.entry_valid = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        chk("reset_ready", 32'(lif.entry_ready), 0);
        chk("reset_we", 32'(lif.we), 0);
        chk("reset_busy", 32'(lif.busy), 0);
        chk("reset_done", 32'(lif.load_done), 0);
        chk("reset_b0", 32'(lif.lut_in_bank0), 0);
        chk("reset_b1", 32'(lif.lut_in_bank1), 0);
        chk("reset_page", 32'(lif.page_write_addr), 0);
        chk("reset_off", 32'(lif.write_addr_offset), 0);
        rst = 1'b0;
        step();
        chk("idle_ignores_valid", 32'(lif.busy), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
